if_predict_stage: RTL and testbench
===================================

# if_predict_stage

Parametrised instruction-fetch stage for the 5-stage MIPS pipeline, successor to the fixed-width fetch unit. It holds the PC, drives an external instruction memory, and predicts taken branches with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. Later stages can redirect the PC on a mispredict or jump. It registers the fetched instruction into the IF/ID pipeline register, with stall and flush.

## Interface
Parameters:
- `XLEN`, 32: address/instruction width.
- `BTB_ENTRIES`, 16: BTB depth; power of two, ≥2.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `pcWrite` in 1: 1 = advance PC and load IF/ID; 0 = stall.
- `flush` in 1: squash IF/ID contents next edge.
- `jmp` in 1: decode-stage jump request.
- `jmpAdr` in 26: jump target field.
- `redirect` in 1: EX-stage mispredict repair.
- `redirectAdr` in XLEN: correct PC for `redirect`.
- `updEn` in 1: BTB update strobe from EX (resolved branch).
- `updPc` in XLEN: PC of resolved branch.
- `updTaken` in 1: branch outcome.
- `updTarget` in XLEN: branch target.
- `imemAdr` out XLEN: equals `pc`, combinational.
- `imemData` in XLEN: instruction, combinational read.
- `ifidInst` out XLEN: registered instruction.
- `ifidPc4` out XLEN: registered `pc+4`.
- `ifidPredTaken` out 1: prediction made for that instruction.
- `ifidValid` out 1: IF/ID holds a real instruction.

## Operation
- Index = `pc[log2(BTB_ENTRIES)+1:2]`. Tag = `pc[XLEN-1:log2(BTB_ENTRIES)+2]`.
- Each BTB entry holds: valid, tag, target, 2-bit counter (SNT=0, WNT=1, WT=2, ST=3).
- Prediction is made when the entry is valid, the tag matches, and counter ≥ WT. The predicted next PC is the entry target; otherwise it is `pc+4`.
- Next-PC priority, highest first:
  - `redirect` → `redirectAdr`. Loads even when `pcWrite=0`.
  - `jmp` → `{pc[XLEN-1:28], jmpAdr, 2'b00}`.
  - Prediction.
  - `pc+4`.
- Lower-priority sources load only when `pcWrite=1`. All additions wrap modulo 2^XLEN.
- IF/ID register:
  - `flush=1` or `redirect=1`: load `ifidInst=0` (NOP) and `ifidValid=0`. This overrides stall.
  - Otherwise, `pcWrite=1`: load `imemData`, `pc+4`, the prediction bit, and `ifidValid=1`.
  - Otherwise: hold.
- BTB update on `updEn`:
  - Tag hit: counter increments (saturating at ST) if `updTaken`, else decrements (saturating at SNT). Target is rewritten when taken.
  - Tag miss, taken: allocate/replace the entry with counter=WT.
  - Tag miss, not taken: no change.
- Update and lookup of the same entry in the same cycle: lookup sees the pre-update value. The write lands at the edge.
- Reset (`rst=0` at an edge): `pc=RESET_PC`, all BTB valid bits 0, `ifidInst=0`, `ifidPc4=0`, `ifidPredTaken=0`, `ifidValid=0`. Reset overrides all other inputs, including mid-stall or mid-update.

## Timing
- Fetch latency is 1 cycle: the instruction at `pc` appears on `ifid*` after the next edge.
- A predicted-taken branch costs 0 bubbles.
- A mispredict costs 2 bubbles: `redirect` is asserted in EX.
- A jump costs 1 bubble: the ID stage asserts `flush` together with `jmp`.
- A BTB update is visible to lookups the cycle after `updEn`.

## Configuration
- `IF_BTB_EN` defined: BTB and prediction are built as described.
- `IF_BTB_EN` undefined:
  - No BTB storage.
  - Prediction is always not-taken and `ifidPredTaken=0`.
  - `upd*` inputs are ignored.
  - `redirect`, `jmp`, stall and flush behave unchanged.

## Structure
- Package `if_pkg` holds:
  - Counter type `bht_state_t` (SNT/WNT/WT/ST).
  - Struct `btb_entry_t` (valid, tag, target, ctr).
  - Constant `NOP_INST = 0`.
  - Index/tag width functions of `XLEN` and `BTB_ENTRIES`.
- Sub-module `if_btb` contains the lookup port and update port, with entry storage and counter logic. It is instantiated only under `IF_BTB_EN`.
- The top level holds the PC, next-PC mux, and IF/ID register.

## Test plan
- Reset: hold `rst=0` 2 cycles, release → `imemAdr=0`; after 3 more edges `imemAdr=0xC` and `ifidPc4=0xC`; `ifidValid=1` from the first edge after release.
- BTB training: `updEn` with `updPc=0x10`, `updTaken=1`, `updTarget=0x40`. On the next fetch of 0x10, the next `imemAdr=0x40` and `ifidPredTaken=1`. After two not-taken updates, the fetch of 0x10 goes to 0x14.
- Priority: `redirect=1` (`redirectAdr=0x80`), `jmp=1`, `pcWrite=0` all in the same cycle → `pc=0x80`, `ifidValid=0`, `ifidInst=0`.
- Stall: `pcWrite=0` for 3 cycles at `pc=0x20` → `pc` and `ifid*` unchanged. Adding `flush` in the 2nd cycle → `ifidInst=0`, `ifidValid=0`, `pc` still 0x20.
- Jump: `pc=0x1000_0008`, `jmp=1`, `jmpAdr=0x000_0100` → `pc=0x1000_0400`.
- Aliasing and wrap:
  - Aliasing: train `pc=0x10` taken, then update `pc=0x50` not-taken with `BTB_ENTRIES=16` → entry unchanged, 0x10 still predicts taken.
  - Wrap: `RESET_PC=0xFFFF_FFFC`, so the fetch after reset → `pc=0`.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared types and helpers for the instruction-fetch stage.
//   bht_state_t     2-bit saturating branch counter (SNT/WNT/WT/ST)
//   btb_entry_t     canonical BTB entry layout (valid, tag, target, ctr),
//                   sized for the widest supported XLEN
//   NOP_INST        instruction word loaded into IF/ID on a squash
//   btb_idx_w/tag_w index and tag widths derived from XLEN and BTB depth
//   ctr_inc/ctr_dec saturating counter steps
package if_pkg;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } bht_state_t;

   localparam int BTB_MAX_XLEN = 64;

   typedef struct packed {
      logic                    valid;
      logic [BTB_MAX_XLEN-1:0] tag;
      logic [BTB_MAX_XLEN-1:0] target;
      bht_state_t              ctr;
   } btb_entry_t;

   localparam logic [31:0] NOP_INST = 32'd0;

   function automatic int btb_idx_w(input int entries);
      return $clog2(entries);
   endfunction

   function automatic int btb_tag_w(input int xlen, input int entries);
      return xlen - $clog2(entries) - 2;
   endfunction

   function automatic bht_state_t ctr_inc(input bht_state_t c);
      case (c)
         SNT:     return WNT;
         WNT:     return WT;
         default: return ST;
      endcase
   endfunction

   function automatic bht_state_t ctr_dec(input bht_state_t c);
      case (c)
         ST:      return WT;
         WT:      return WNT;
         default: return SNT;
      endcase
   endfunction

endpackage

// File: rtl/if_btb.sv
// if_btb: direct-mapped branch target buffer with 2-bit saturating counters.
// Only built when IF_BTB_EN is defined.
// Ports:
//   clk, rst          clock, synchronous active-low reset (clears valid bits)
//   lk_pc             word address being fetched (pc[XLEN-1:2])
//   pred_taken        entry valid, tag match, counter >= WT
//   pred_target       stored target of the indexed entry
//   upd_en            resolved-branch update strobe
//   upd_pc            word address of the resolved branch
//   upd_taken         branch outcome
//   upd_target        branch target
// Lookup is purely combinational from storage, so a same-cycle update to the
// same entry is only seen by lookups after the edge.
module if_btb
   import if_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:2] lk_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_en,
   input  logic [XLEN-1:2] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target
);

   localparam int IW = btb_idx_w(BTB_ENTRIES);
   localparam int TW = btb_tag_w(XLEN, BTB_ENTRIES);

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TW-1:0]          tag_q [BTB_ENTRIES];
   logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
   bht_state_t             ctr_q [BTB_ENTRIES];

   logic [IW-1:0] lk_idx;
   logic [IW-1:0] upd_idx;
   logic [TW-1:0] lk_tag;
   logic [TW-1:0] upd_tag;
   logic          lk_hit;
   logic          upd_hit;

   assign lk_idx  = lk_pc[IW+1:2];
   assign lk_tag  = lk_pc[XLEN-1:IW+2];
   assign upd_idx = upd_pc[IW+1:2];
   assign upd_tag = upd_pc[XLEN-1:IW+2];

   assign lk_hit  = valid_q[lk_idx]  && (tag_q[lk_idx]  == lk_tag);
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   // counter MSB set means WT or ST
   assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
   assign pred_target = tgt_q[lk_idx];

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (upd_en) begin
         if (upd_hit) begin
            ctr_q[upd_idx] <= upd_taken ? ctr_inc(ctr_q[upd_idx]) : ctr_dec(ctr_q[upd_idx]);
            if (upd_taken) begin
               tgt_q[upd_idx] <= upd_target;
            end
         end else if (upd_taken) begin
            // a taken miss replaces whatever aliased into this slot
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= upd_target;
            ctr_q[upd_idx]   <= WT;
         end
      end
   end

endmodule

// File: rtl/if_predict_stage.sv
// if_predict_stage: instruction-fetch stage with PC, next-PC selection,
// optional BTB branch prediction and the IF/ID pipeline register.
// Build option: define IF_BTB_EN to include the BTB (if_btb); without it
// prediction is always not-taken and the upd* inputs are ignored.
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   pcWrite                1 = advance PC and load IF/ID, 0 = stall
//   flush                  squash IF/ID at next edge
//   jmp, jmpAdr            decode-stage jump and 26-bit target field
//   redirect, redirectAdr  EX-stage mispredict repair (ignores stall)
//   updEn, updPc, updTaken, updTarget   BTB training from EX
//   imemAdr, imemData      instruction memory address / combinational data
//   ifidInst, ifidPc4, ifidPredTaken, ifidValid   IF/ID register outputs
module if_predict_stage
   import if_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              BTB_ENTRIES = 16,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pcWrite,
   input  logic            flush,
   input  logic            jmp,
   input  logic [25:0]     jmpAdr,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirectAdr,
   input  logic            updEn,
   input  logic [XLEN-1:0] updPc,
   input  logic            updTaken,
   input  logic [XLEN-1:0] updTarget,
   output logic [XLEN-1:0] imemAdr,
   input  logic [XLEN-1:0] imemData,
   output logic [XLEN-1:0] ifidInst,
   output logic [XLEN-1:0] ifidPc4,
   output logic            ifidPredTaken,
   output logic            ifidValid
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc4;
   logic [XLEN-1:0] jmp_target;
   logic [XLEN-1:0] seq_next;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;

   assign imemAdr    = pc;
   assign pc4        = pc + XLEN'(4);
   assign jmp_target = {pc[XLEN-1:28], jmpAdr, 2'b00};

`ifdef IF_BTB_EN
   if_btb #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .lk_pc       (pc[XLEN-1:2]),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_en      (updEn),
      .upd_pc      (updPc[XLEN-1:2]),
      .upd_taken   (updTaken),
      .upd_target  (updTarget)
   );

   // branch PCs are word aligned, the byte offset carries no information
   logic unused_upd_lsb;
   assign unused_upd_lsb = ^updPc[1:0];
`else
   assign pred_taken  = 1'b0;
   assign pred_target = '0;

   logic unused_upd;
   assign unused_upd = ^{updEn, updPc, updTaken, updTarget};
`endif

   // sources that only load when the pipe is not stalled
   always_comb begin
      seq_next = pc4;
      if (jmp) begin
         seq_next = jmp_target;
      end else if (pred_taken) begin
         seq_next = pred_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc            <= RESET_PC;
         ifidInst      <= XLEN'(NOP_INST);
         ifidPc4       <= '0;
         ifidPredTaken <= 1'b0;
         ifidValid     <= 1'b0;
      end else begin
         if (redirect) begin
            pc <= redirectAdr;
         end else if (pcWrite) begin
            pc <= seq_next;
         end

         // a redirect squashes the wrong-path fetch even during a stall
         if (flush || redirect) begin
            ifidInst  <= XLEN'(NOP_INST);
            ifidValid <= 1'b0;
         end else if (pcWrite) begin
            ifidInst      <= imemData;
            ifidPc4       <= pc4;
            ifidPredTaken <= pred_taken;
            ifidValid     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_if_predict_stage.sv
module tb_if_predict_stage;

`ifdef IF_BTB_EN
   localparam bit BTB_ON = 1'b1;
`else
   localparam bit BTB_ON = 1'b0;
`endif
   // where a fetch of 0x10 goes when the BTB entry predicts taken
   localparam logic [31:0] TAKEN_NPC  = BTB_ON ? 32'h40 : 32'h14;
   localparam logic [31:0] TAKEN_NPC2 = BTB_ON ? 32'h60 : 32'h14;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_write = 1'b1;
   logic        flush = 1'b0;
   logic        jmp = 1'b0;
   logic [25:0] jmp_adr = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_adr = '0;
   logic        upd_en = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;

   logic [31:0] imem_adr, imem_data, ifid_inst, ifid_pc4;
   logic        ifid_pred, ifid_valid;
   logic [31:0] w_imem_adr, w_imem_data, w_ifid_inst, w_ifid_pc4;
   logic        w_ifid_pred, w_ifid_valid;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h2408_0000;
   endfunction

   assign imem_data   = inst_of(imem_adr);
   assign w_imem_data = inst_of(w_imem_adr);

   if_predict_stage #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .pcWrite(pc_write), .flush(flush), .jmp(jmp), .jmpAdr(jmp_adr),
      .redirect(redirect), .redirectAdr(redirect_adr), .updEn(upd_en), .updPc(upd_pc),
      .updTaken(upd_taken), .updTarget(upd_target), .imemAdr(imem_adr), .imemData(imem_data),
      .ifidInst(ifid_inst), .ifidPc4(ifid_pc4), .ifidPredTaken(ifid_pred), .ifidValid(ifid_valid)
   );

   if_predict_stage #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .pcWrite(pc_write), .flush(flush), .jmp(jmp), .jmpAdr(jmp_adr),
      .redirect(redirect), .redirectAdr(redirect_adr), .updEn(upd_en), .updPc(upd_pc),
      .updTaken(upd_taken), .updTarget(upd_target), .imemAdr(w_imem_adr), .imemData(w_imem_data),
      .ifidInst(w_ifid_inst), .ifidPc4(w_ifid_pc4), .ifidPredTaken(w_ifid_pred), .ifidValid(w_ifid_valid)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_pc(input logic [31:0] a);
      redirect = 1'b1; redirect_adr = a;
      tick(1);
      redirect = 1'b0;
   endtask

   task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt);
      upd_en = 1'b1; upd_pc = p; upd_taken = t; upd_target = tgt;
   endtask

   task automatic test_reset;
      rst = 1'b0; pc_write = 1'b1;
      tick(2);
      n_checks++; if (imem_adr !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=%h", imem_adr, 32'h0); end
      n_checks++; if (ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_pred !== 1'b0) begin
         n_fail++; $display("FAIL rst_ifid got v=%b i=%h p4=%h pt=%b exp all zero", ifid_valid, ifid_inst, ifid_pc4, ifid_pred); end
      n_checks++; if (w_imem_adr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_pc_wrap got=%h exp=%h", w_imem_adr, 32'hFFFF_FFFC); end
      rst = 1'b1;
      tick(1);
      n_checks++; if (imem_adr !== 32'h4 || ifid_valid !== 1'b1 || ifid_pc4 !== 32'h4 || ifid_inst !== inst_of(32'h0)) begin
         n_fail++; $display("FAIL first_fetch got pc=%h v=%b p4=%h i=%h exp pc=4 v=1 p4=4 i=%h", imem_adr, ifid_valid, ifid_pc4, ifid_inst, inst_of(32'h0)); end
      n_checks++; if (w_imem_adr !== 32'h0 || w_ifid_pc4 !== 32'h0) begin
         n_fail++; $display("FAIL wrap_fetch got pc=%h p4=%h exp 0 0", w_imem_adr, w_ifid_pc4); end
      tick(2);
      n_checks++; if (imem_adr !== 32'hC || ifid_pc4 !== 32'hC) begin
         n_fail++; $display("FAIL seq_fetch got pc=%h p4=%h exp C C", imem_adr, ifid_pc4); end
   endtask

   task automatic test_btb_train;
      upd(32'h10, 1'b1, 32'h40);
      set_pc(32'h8);
      upd_en = 1'b0;
      n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_squash got v=%b exp 0", ifid_valid); end
      tick(2);
      n_checks++; if (imem_adr !== 32'h10) begin n_fail++; $display("FAIL walk_to_10 got=%h exp 10", imem_adr); end
      tick(1);
      n_checks++; if (imem_adr !== TAKEN_NPC || ifid_pred !== BTB_ON) begin
         n_fail++; $display("FAIL btb_predict got pc=%h pt=%b exp pc=%h pt=%b", imem_adr, ifid_pred, TAKEN_NPC, BTB_ON); end
      n_checks++; if (ifid_pc4 !== 32'h14 || ifid_inst !== inst_of(32'h10) || ifid_valid !== 1'b1) begin
         n_fail++; $display("FAIL btb_ifid got p4=%h i=%h v=%b exp p4=14 i=%h v=1", ifid_pc4, ifid_inst, ifid_valid, inst_of(32'h10)); end
      upd(32'h10, 1'b0, 32'h0);
      tick(2);
      upd_en = 1'b0;
      set_pc(32'h10);
      tick(1);
      n_checks++; if (imem_adr !== 32'h14 || ifid_pred !== 1'b0) begin
         n_fail++; $display("FAIL btb_untrain got pc=%h pt=%b exp 14 0", imem_adr, ifid_pred); end
   endtask

   task automatic test_same_cycle;
      upd(32'h10, 1'b1, 32'h40);     // SNT -> WNT
      set_pc(32'h10);
      tick(1);                        // WNT -> WT, lookup sees WNT
      upd_en = 1'b0;
      n_checks++; if (imem_adr !== 32'h14 || ifid_pred !== 1'b0) begin
         n_fail++; $display("FAIL same_cycle_pre got pc=%h pt=%b exp 14 0", imem_adr, ifid_pred); end
      set_pc(32'h10);
      tick(1);
      n_checks++; if (imem_adr !== TAKEN_NPC || ifid_pred !== BTB_ON) begin
         n_fail++; $display("FAIL same_cycle_post got pc=%h pt=%b exp %h %b", imem_adr, ifid_pred, TAKEN_NPC, BTB_ON); end
   endtask

   task automatic test_alias;
      upd(32'h50, 1'b0, 32'h0);       // same index as 0x10, different tag
      tick(1);
      upd_en = 1'b0;
      set_pc(32'h10);
      tick(1);
      n_checks++; if (imem_adr !== TAKEN_NPC || ifid_pred !== BTB_ON) begin
         n_fail++; $display("FAIL alias got pc=%h pt=%b exp %h %b", imem_adr, ifid_pred, TAKEN_NPC, BTB_ON); end
      upd(32'h10, 1'b1, 32'h40); tick(1);   // WT -> ST
      upd(32'h10, 1'b1, 32'h40); tick(1);   // stays ST
      upd(32'h10, 1'b0, 32'h0);  tick(1);   // ST -> WT
      upd_en = 1'b0;
      set_pc(32'h10);
      tick(1);
      n_checks++; if (imem_adr !== TAKEN_NPC) begin n_fail++; $display("FAIL sat_st got=%h exp=%h", imem_adr, TAKEN_NPC); end
      upd(32'h10, 1'b0, 32'h0); tick(1);    // WT -> WNT
      upd_en = 1'b0;
      set_pc(32'h10);
      tick(1);
      n_checks++; if (imem_adr !== 32'h14) begin n_fail++; $display("FAIL wt_to_wnt got=%h exp 14", imem_adr); end
      upd(32'h10, 1'b1, 32'h60); tick(1);   // WNT -> WT, new target
      upd_en = 1'b0;
      set_pc(32'h10);
      tick(1);
      n_checks++; if (imem_adr !== TAKEN_NPC2) begin n_fail++; $display("FAIL retarget got=%h exp=%h", imem_adr, TAKEN_NPC2); end
   endtask

   task automatic test_priority;
      set_pc(32'h30);
      tick(1);
      redirect = 1'b1; redirect_adr = 32'h80; jmp = 1'b1; jmp_adr = 26'h3FF; pc_write = 1'b0;
      tick(1);
      redirect = 1'b0; jmp = 1'b0; pc_write = 1'b1;
      n_checks++; if (imem_adr !== 32'h80 || ifid_valid !== 1'b0 || ifid_inst !== 32'h0) begin
         n_fail++; $display("FAIL priority got pc=%h v=%b i=%h exp 80 0 0", imem_adr, ifid_valid, ifid_inst); end
   endtask

   task automatic test_stall;
      set_pc(32'h1C);
      tick(1);
      pc_write = 1'b0;
      tick(1);
      n_checks++; if (imem_adr !== 32'h20 || ifid_inst !== inst_of(32'h1C) || ifid_pc4 !== 32'h20 || ifid_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_hold got pc=%h i=%h p4=%h v=%b exp 20 %h 20 1", imem_adr, ifid_inst, ifid_pc4, ifid_valid, inst_of(32'h1C)); end
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      n_checks++; if (imem_adr !== 32'h20 || ifid_inst !== 32'h0 || ifid_valid !== 1'b0) begin
         n_fail++; $display("FAIL stall_flush got pc=%h i=%h v=%b exp 20 0 0", imem_adr, ifid_inst, ifid_valid); end
      tick(1);
      n_checks++; if (imem_adr !== 32'h20 || ifid_valid !== 1'b0) begin
         n_fail++; $display("FAIL stall_3rd got pc=%h v=%b exp 20 0", imem_adr, ifid_valid); end
      pc_write = 1'b1;
      tick(1);
      n_checks++; if (imem_adr !== 32'h24 || ifid_inst !== inst_of(32'h20) || ifid_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_resume got pc=%h i=%h v=%b exp 24 %h 1", imem_adr, ifid_inst, ifid_valid, inst_of(32'h20)); end
   endtask

   task automatic test_jump;
      set_pc(32'h1000_0008);
      jmp = 1'b1; jmp_adr = 26'h000_0100; pc_write = 1'b0;
      tick(1);
      n_checks++; if (imem_adr !== 32'h1000_0008) begin n_fail++; $display("FAIL jmp_stalled got=%h exp 10000008", imem_adr); end
      pc_write = 1'b1; flush = 1'b1;
      tick(1);
      jmp = 1'b0; flush = 1'b0;
      n_checks++; if (imem_adr !== 32'h1000_0400 || ifid_valid !== 1'b0) begin
         n_fail++; $display("FAIL jmp_target got pc=%h v=%b exp 10000400 0", imem_adr, ifid_valid); end
      tick(1);
      n_checks++; if (ifid_inst !== inst_of(32'h1000_0400) || ifid_pc4 !== 32'h1000_0404 || imem_adr !== 32'h1000_0404) begin
         n_fail++; $display("FAIL jmp_fetch got i=%h p4=%h pc=%h exp %h 10000404 10000404", ifid_inst, ifid_pc4, imem_adr, inst_of(32'h1000_0400)); end
   endtask

   task automatic test_reset_mid;
      pc_write = 1'b0; rst = 1'b0;
      upd(32'h10, 1'b1, 32'h70);
      tick(1);
      upd_en = 1'b0; rst = 1'b1; pc_write = 1'b1;
      n_checks++; if (imem_adr !== 32'h0 || ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid got pc=%h v=%b p4=%h exp 0 0 0", imem_adr, ifid_valid, ifid_pc4); end
      set_pc(32'h10);
      tick(1);
      n_checks++; if (imem_adr !== 32'h14 || ifid_pred !== 1'b0) begin
         n_fail++; $display("FAIL rst_clears_btb got pc=%h pt=%b exp 14 0", imem_adr, ifid_pred); end
   endtask

   initial begin
      #1;
      test_reset();
      test_btb_train();
      test_same_cycle();
      test_alias();
      test_priority();
      test_stall();
      test_jump();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
